hazard_tracker: RTL and testbench

- Decides each cycle whether the ID stage must stall.
- Mirrors the destination register, write-enable and load flag of the instructions now in EXE, MEM and WB in its own three-entry in-flight pipeline.
- Compares the decoding instruction's source registers against that pipeline.
- Drives the `hazard` input of the ID stage and the freeze of the IF and ID registers.
- Counts stall cycles for performance monitoring.

---
 rtl/hazard_tracker.sv | 117 +++++++++++
 tb/tb_hazard_tracker.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_tracker.sv
// hazard_tracker: ID-stage stall decision for the five-stage pipeline.
// Mirrors {valid, dest, load} of the instructions in EXE, MEM and WB. The
// current ID instruction's source registers are compared against the EXE
// and MEM entries to request a stall.
// Optional feature macro: HAZARD_FORWARDING_EN. When it is defined, only
// load-use hazards stall. When it is undefined, the block is a full
// interlock that assumes no forwarding.
// dbg_pipe_o exposes the in-flight pipeline as {E, M, W}. Each entry is
// packed as {v, dest[3:0], ld}.
module hazard_tracker #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [3:0]       id_src1,
  input  logic             id_src1_en,
  input  logic [3:0]       id_src2,
  input  logic             id_two_src,
  input  logic [3:0]       id_dest,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic             freeze,
  input  logic             flush,
  output logic             hazard,
  output logic [CNT_W-1:0] stall_count,
  output logic [17:0]      dbg_pipe_o
);

  typedef struct packed {
    logic       v;
    logic [3:0] dest;
    logic       ld;
  } entry_t;

  entry_t e_q, e_d;
  entry_t m_q, m_d;
  entry_t w_q, w_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic m_e;

  // Source-match term against the EXE entry. A source only counts when the
  // instruction actually reads it.
  always_comb begin
    m_e = (e_q.v & id_src1_en & (e_q.dest == id_src1)) |
          (e_q.v & id_two_src & (e_q.dest == id_src2));
  end

`ifdef HAZARD_FORWARDING_EN
  // Forwarding covers ALU results. Only a load in EXE must stall its consumer.
  always_comb begin
    hazard = id_valid & ~flush & e_q.ld & m_e;
  end
`else
  logic m_m;

  // Source-match term against the MEM entry. WB never matches, because the
  // register file writes on the falling edge.
  always_comb begin
    m_m = (m_q.v & id_src1_en & (m_q.dest == id_src1)) |
          (m_q.v & id_two_src & (m_q.dest == id_src2));
  end

  // Full interlock: any producer still in EXE or MEM stalls the consumer.
  always_comb begin
    hazard = id_valid & ~flush & (m_e | m_m);
  end
`endif

  // Pipeline advance. A stalled or flushed ID instruction enters EXE as a
  // bubble. Freeze holds every entry.
  always_comb begin
    e_d = e_q;
    m_d = m_q;
    w_d = w_q;
    if (!freeze) begin
      e_d.v    = id_valid & id_wb_en & ~hazard & ~flush;
      e_d.dest = id_dest;
      e_d.ld   = id_mem_r_en;
      m_d      = e_q;
      w_d      = m_q;
    end
  end

  // Stall-cycle counter. It counts only non-frozen hazard cycles and holds
  // at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (hazard && !freeze && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers. An asynchronous reset clears all in-flight state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_q   <= '0;
      m_q   <= '0;
      w_q   <= '0;
      cnt_q <= '0;
    end else begin
      e_q   <= e_d;
      m_q   <= m_d;
      w_q   <= w_d;
      cnt_q <= cnt_d;
    end
  end

  // Output mapping.
  always_comb begin
    stall_count = cnt_q;
    dbg_pipe_o  = {e_q, m_q, w_q};
  end

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed testbench for hazard_tracker.
// It instantiates two copies that share their inputs: the default-width
// counter and a 4-bit counter used to observe saturation.
module tb_hazard_tracker;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [3:0]  id_src1;
  logic        id_src1_en;
  logic [3:0]  id_src2;
  logic        id_two_src;
  logic [3:0]  id_dest;
  logic        id_wb_en;
  logic        id_mem_r_en;
  logic        freeze;
  logic        flush;
  logic        hazard;
  logic        hazard_s;
  logic [15:0] stall_count;
  logic [3:0]  stall_count_s;
  logic [17:0] dbg;
  logic [17:0] dbg_s;

  int checks   = 0;
  int failures = 0;

  hazard_tracker #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_src1(id_src1), .id_src1_en(id_src1_en),
    .id_src2(id_src2), .id_two_src(id_two_src),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .freeze(freeze), .flush(flush),
    .hazard(hazard), .stall_count(stall_count), .dbg_pipe_o(dbg)
  );

  hazard_tracker #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_src1(id_src1), .id_src1_en(id_src1_en),
    .id_src2(id_src2), .id_two_src(id_two_src),
    .id_dest(id_dest), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .freeze(freeze), .flush(flush),
    .hazard(hazard_s), .stall_count(stall_count_s), .dbg_pipe_o(dbg_s)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog
  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [3:0] s1, input logic s1en,
                        input logic [3:0] s2, input logic two,
                        input logic [3:0] d, input logic wb, input logic ld);
    id_valid    = v;
    id_src1     = s1;
    id_src1_en  = s1en;
    id_src2     = s2;
    id_two_src  = two;
    id_dest     = d;
    id_wb_en    = wb;
    id_mem_r_en = ld;
    #1;
  endtask

  task automatic idle();
    set_id(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    idle();
    tick();
    tick();
    tick();
  endtask

  // Directed stimulus
  initial begin
    rst    = 1'b0;
    freeze = 1'b0;
    flush  = 1'b0;
    idle();
    #2;
    chk("rst_hazard", {31'd0, hazard}, 32'd0);
    chk("rst_count", {16'd0, stall_count}, 32'd0);
    chk("rst_pipe", {14'd0, dbg}, 32'd0);
    #10 rst = 1'b1;
    tick();

`ifdef HAZARD_FORWARDING_EN
    // Load-use: LDR R2 followed by an ADD that reads R2 as its second source.
    set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b1);
    chk("lu_first", {31'd0, hazard}, 32'd0);
    tick();
    set_id(1'b1, 4'd0, 1'b1, 4'd2, 1'b1, 4'd4, 1'b1, 1'b0);
    chk("lu_stall", {31'd0, hazard}, 32'd1);
    tick();
    chk("lu_resolve", {31'd0, hazard}, 32'd0);
    chk("lu_count", {16'd0, stall_count}, 32'd1);
    drain();
    // The same pair with an ALU producer is covered by forwarding.
    set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 4'd0, 1'b1, 4'd2, 1'b1, 4'd4, 1'b1, 1'b0);
    chk("alu_nostall", {31'd0, hazard}, 32'd0);
    tick();
    chk("alu_issued_e", {26'd0, dbg[17:12]}, 32'h28);
    chk("alu_count", {16'd0, stall_count}, 32'd1);
    drain();
`else
    // Back-to-back RAW: ADD R1, then SUB reading R1.
    set_id(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0);
    chk("raw_prod", {31'd0, hazard}, 32'd0);
    tick();
    set_id(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0);
    chk("raw_hz0", {31'd0, hazard}, 32'd1);
    chk("raw_cnt0", {16'd0, stall_count}, 32'd0);
    chk("raw_e_prod", {26'd0, dbg[17:12]}, 32'h22);
    tick();
    chk("raw_hz1", {31'd0, hazard}, 32'd1);
    chk("raw_cnt1", {16'd0, stall_count}, 32'd1);
    chk("raw_e_bub1", {31'd0, dbg[17]}, 32'd0);
    tick();
    chk("raw_hz2", {31'd0, hazard}, 32'd0);
    chk("raw_cnt2", {16'd0, stall_count}, 32'd2);
    chk("raw_e_bub2", {31'd0, dbg[17]}, 32'd0);
    chk("raw_w_prod", {26'd0, dbg[5:0]}, 32'h22);
    chk("raw_sat2", {28'd0, stall_count_s}, 32'd2);
    tick();
    chk("raw_e_issued", {26'd0, dbg[17:12]}, 32'h28);
    drain();

    // One instruction in between, with R15 as dest and second source.
    set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd15, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0);
    chk("gap_indep", {31'd0, hazard}, 32'd0);
    tick();
    set_id(1'b1, 4'd0, 1'b1, 4'd15, 1'b1, 4'd7, 1'b0, 1'b0);
    chk("gap_r15_hz", {31'd0, hazard}, 32'd1);
    tick();
    chk("gap_resolve", {31'd0, hazard}, 32'd0);
    chk("gap_cnt", {16'd0, stall_count}, 32'd3);
    drain();

    // Unused operand fields that equal an in-flight dest.
    set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 4'd7, 1'b0, 4'd7, 1'b0, 4'd8, 1'b1, 1'b0);
    chk("mov_nohz", {31'd0, hazard}, 32'd0);
    set_id(1'b1, 4'd7, 1'b1, 4'd7, 1'b0, 4'd8, 1'b1, 1'b0);
    chk("src1en_hz", {31'd0, hazard}, 32'd1);
    set_id(1'b0, 4'd7, 1'b1, 4'd7, 1'b0, 4'd8, 1'b1, 1'b0);
    chk("bubble_nohz", {31'd0, hazard}, 32'd0);
    drain();

    // Freeze for 3 cycles in the middle of a stall.
    set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd10, 1'b1, 1'b0);
    freeze = 1'b1;
    #1;
    chk("frz_hz_start", {31'd0, hazard}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frz_hz", {31'd0, hazard}, 32'd1);
      chk("frz_cnt", {16'd0, stall_count}, 32'd3);
      chk("frz_e_hold", {26'd0, dbg[17:12]}, 32'h26);
    end
    freeze = 1'b0;
    #1;
    tick();
    chk("frz_post_hz1", {31'd0, hazard}, 32'd1);
    chk("frz_post_cnt1", {16'd0, stall_count}, 32'd4);
    chk("frz_post_bub", {31'd0, dbg[17]}, 32'd0);
    tick();
    chk("frz_post_hz0", {31'd0, hazard}, 32'd0);
    chk("frz_post_cnt2", {16'd0, stall_count}, 32'd5);
    tick();
    chk("frz_issued", {26'd0, dbg[17:12]}, 32'h34);
    drain();

    // A flush masks the hazard and sends a bubble into E.
    set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd9, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 4'd9, 1'b1, 4'd0, 1'b0, 4'd11, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    chk("flush_hz", {31'd0, hazard}, 32'd0);
    tick();
    flush = 1'b0;
    chk("flush_e_bub", {31'd0, dbg[17]}, 32'd0);
    chk("flush_m_prod", {26'd0, dbg[11:6]}, 32'h32);
    chk("flush_cnt", {16'd0, stall_count}, 32'd5);
    drain();

    // Eight more RAW pairs add 16 stalls, giving 21 in total.
    for (int i = 0; i < 8; i++) begin
      set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd1, 1'b1, 1'b0);
      tick();
      set_id(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0);
      tick();
      tick();
      tick();
    end
    drain();
    chk("loop_cnt", {16'd0, stall_count}, 32'd21);
    chk("sat_cnt", {28'd0, stall_count_s}, 32'd15);
    tick();
    chk("sat_hold", {28'd0, stall_count_s}, 32'd15);
`endif

    // Asynchronous reset in the middle of a cycle during a stall.
    set_id(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0);
    chk("mid_hz", {31'd0, hazard}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_hz", {31'd0, hazard}, 32'd0);
    chk("arst_cnt", {16'd0, stall_count}, 32'd0);
    chk("arst_sat_cnt", {28'd0, stall_count_s}, 32'd0);
    chk("arst_pipe", {14'd0, dbg}, 32'd0);
    #2 rst = 1'b1;
    idle();
    tick();

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
